// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe DLLP receive path: SDP token, DLLP type codes,
// data link state encoding and the CRC16 constants used by pcie_dllp_crc16.
package pcie_pkg;

    localparam int PIPE_DATA_WIDTH = 256;

    localparam logic [7:0] SDP_BYTE0 = 8'hF0;
    localparam logic [7:0] SDP_BYTE1 = 8'hAC;

    localparam logic [7:0] DLLP_ACK         = 8'h00;
    localparam logic [7:0] DLLP_NAK         = 8'h10;
    localparam logic [7:0] DLLP_INITFC1_P   = 8'h40;
    localparam logic [7:0] DLLP_INITFC1_NP  = 8'h50;
    localparam logic [7:0] DLLP_INITFC1_CPL = 8'h60;
    localparam logic [7:0] DLLP_UPDFC_P     = 8'h80;
    localparam logic [7:0] DLLP_UPDFC_NP    = 8'h90;
    localparam logic [7:0] DLLP_UPDFC_CPL   = 8'hA0;
    localparam logic [7:0] DLLP_INITFC2_P   = 8'hC0;
    localparam logic [7:0] DLLP_INITFC2_NP  = 8'hD0;
    localparam logic [7:0] DLLP_INITFC2_CPL = 8'hE0;

    localparam logic [15:0] CRC16_POLY = 16'h100B;
    localparam logic [15:0] CRC16_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        DL_INACTIVE = 2'd0,
        DL_INIT1    = 2'd1,
        DL_INIT2    = 2'd2,
        DL_ACTIVE   = 2'd3
    } dl_state_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ACK,
        CLS_NAK,
        CLS_INITFC1,
        CLS_INITFC2,
        CLS_UPDFC
    } dllp_cls_t;

    // FC type (P/NP/Cpl) is carried in type bits [5:4] for all three FC families.
    function automatic dllp_cls_t dllp_class(input logic [7:0] dtype);
        dllp_cls_t cls;
        case (dtype)
            DLLP_ACK:                                           cls = CLS_ACK;
            DLLP_NAK:                                           cls = CLS_NAK;
            DLLP_INITFC1_P, DLLP_INITFC1_NP, DLLP_INITFC1_CPL:  cls = CLS_INITFC1;
            DLLP_INITFC2_P, DLLP_INITFC2_NP, DLLP_INITFC2_CPL:  cls = CLS_INITFC2;
            DLLP_UPDFC_P, DLLP_UPDFC_NP, DLLP_UPDFC_CPL:        cls = CLS_UPDFC;
            default:                                            cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/pcie_dllp_crc16.sv
// Combinational DLLP CRC16 over the 4 content bytes, {byte2,byte3,byte4,byte5},
// each byte shifted in MSB first, seeded with all ones, no final inversion.
module pcie_dllp_crc16
    import pcie_pkg::*;
(
    input  logic [31:0] data,
    output logic [15:0] crc
);

    logic [15:0] acc;

    always_comb begin
        acc = CRC16_SEED;
        for (int i = 31; i >= 0; i--) begin
            acc = {acc[14:0], 1'b0} ^ ((acc[15] ^ data[i]) ? CRC16_POLY : 16'h0000);
        end
        crc = acc;
    end

endmodule

// File: rtl/pcie_dllp_rx.sv
// PCIe DLLP receiver: SDP detect, 2-stage decode, DLCMSM, FC credit limits, Ack/Nak.
// Define PCIE_DLLP_RX_CRC_CHECK_EN to check the DLLP CRC16 and report bad DLLPs.
//   state       | meaning
//   DL_INACTIVE | link down, all limits and flags cleared
//   DL_INIT1    | collecting InitFC1 P/NP/Cpl
//   DL_INIT2    | waiting for first InitFC2/UpdateFC
//   DL_ACTIVE   | UpdateFC and Ack/Nak processed
module pcie_dllp_rx #(
    parameter int PIPE_DATA_WIDTH = pcie_pkg::PIPE_DATA_WIDTH
) (
    input  logic                       sclk,
    input  logic                       sreset_n,
    input  logic                       link_up_i,
    input  logic                       pipe_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0] pipe_data_i,
    output logic [1:0]                 dl_state_o,
    output logic                       fc_init1_done_o,
    output logic                       fc_init2_done_o,
    output logic                       ack_valid_o,
    output logic                       ack_nak_o,
    output logic [11:0]                ack_seq_o,
    output logic [7:0]                 hdr_cl_p_o,
    output logic [7:0]                 hdr_cl_np_o,
    output logic [7:0]                 hdr_cl_cpl_o,
    output logic [11:0]                data_cl_p_o,
    output logic [11:0]                data_cl_np_o,
    output logic [11:0]                data_cl_cpl_o,
    output logic [2:0]                 inf_hdr_o,
    output logic [2:0]                 inf_data_o,
    output logic                       crc_err_o
);
    import pcie_pkg::*;

    dl_state_t   state;
    logic [7:0]  hdr_cl  [3];
    logic [11:0] data_cl [3];
    logic [2:0]  fc1_got;

    logic        sdp_hit;
    logic [31:0] beat_dllp;
    logic        s1_vld;
    logic [31:0] s1_dllp;
    logic        crc_ok;

    assign sdp_hit   = pipe_valid_i && (pipe_data_i[7:0] == SDP_BYTE0)
                                    && (pipe_data_i[15:8] == SDP_BYTE1);
    assign beat_dllp = {pipe_data_i[23:16], pipe_data_i[31:24],
                        pipe_data_i[39:32], pipe_data_i[47:40]};

    // Dropping link_up flushes stage 1 so nothing in flight lands after re-training.
    always_ff @(posedge sclk or negedge sreset_n) begin
        if (!sreset_n) begin
            s1_vld  <= 1'b0;
            s1_dllp <= '0;
        end else begin
            s1_vld <= link_up_i && sdp_hit;
            if (sdp_hit) s1_dllp <= beat_dllp;
        end
    end

`ifdef PCIE_DLLP_RX_CRC_CHECK_EN
    logic [15:0] crc_calc;
    logic [15:0] s1_crc_calc;
    logic [15:0] s1_crc_rx;
    logic        unused_bits;

    pcie_dllp_crc16 u_crc16 (
        .data (beat_dllp),
        .crc  (crc_calc)
    );

    always_ff @(posedge sclk or negedge sreset_n) begin
        if (!sreset_n) begin
            s1_crc_calc <= '0;
            s1_crc_rx   <= '0;
        end else if (sdp_hit) begin
            s1_crc_calc <= crc_calc;
            s1_crc_rx   <= {pipe_data_i[55:48], pipe_data_i[63:56]};
        end
    end

    assign crc_ok = (s1_crc_calc == s1_crc_rx);

    always_ff @(posedge sclk or negedge sreset_n) begin
        if (!sreset_n) crc_err_o <= 1'b0;
        else           crc_err_o <= link_up_i && s1_vld && !crc_ok;
    end

    assign unused_bits = ^{pipe_data_i[PIPE_DATA_WIDTH-1:64], s1_dllp[23:22], s1_dllp[13:12]};
`else
    logic unused_bits;

    assign crc_ok      = 1'b1;
    assign crc_err_o   = 1'b0;
    assign unused_bits = ^{pipe_data_i[PIPE_DATA_WIDTH-1:48], s1_dllp[23:22], s1_dllp[13:12]};
`endif

    dllp_cls_t   cls;
    logic [1:0]  fc_idx;
    logic [7:0]  hdr_fc;
    logic [11:0] data_fc;
    logic        accept;
    logic [2:0]  ifc1_mask;

    assign cls       = dllp_class(s1_dllp[31:24]);
    assign fc_idx    = s1_dllp[29:28];
    assign hdr_fc    = {s1_dllp[21:16], s1_dllp[15:14]};
    assign data_fc   = s1_dllp[11:0];
    assign accept    = s1_vld && crc_ok;
    assign ifc1_mask = (accept && cls == CLS_INITFC1) ? (3'b001 << fc_idx) : 3'b000;

    always_ff @(posedge sclk or negedge sreset_n) begin
        if (!sreset_n) begin
            state           <= DL_INACTIVE;
            fc1_got         <= '0;
            fc_init1_done_o <= 1'b0;
            fc_init2_done_o <= 1'b0;
            ack_valid_o     <= 1'b0;
            ack_nak_o       <= 1'b0;
            ack_seq_o       <= '0;
            inf_hdr_o       <= '0;
            inf_data_o      <= '0;
            for (int i = 0; i < 3; i++) begin
                hdr_cl[i]  <= '0;
                data_cl[i] <= '0;
            end
        end else if (!link_up_i) begin
            state           <= DL_INACTIVE;
            fc1_got         <= '0;
            fc_init1_done_o <= 1'b0;
            fc_init2_done_o <= 1'b0;
            ack_valid_o     <= 1'b0;
            ack_nak_o       <= 1'b0;
            ack_seq_o       <= '0;
            inf_hdr_o       <= '0;
            inf_data_o      <= '0;
            for (int i = 0; i < 3; i++) begin
                hdr_cl[i]  <= '0;
                data_cl[i] <= '0;
            end
        end else begin
            ack_valid_o <= 1'b0;
            case (state)
                DL_INACTIVE: state <= DL_INIT1;
                DL_INIT1: begin
                    if (fc_init1_done_o) state <= DL_INIT2;
                    if (ifc1_mask != 3'b000) begin
                        hdr_cl[fc_idx]     <= hdr_fc;
                        data_cl[fc_idx]    <= data_fc;
                        inf_hdr_o[fc_idx]  <= (hdr_fc == 8'h00);
                        inf_data_o[fc_idx] <= (data_fc == 12'h000);
                    end
                    fc1_got         <= fc1_got | ifc1_mask;
                    fc_init1_done_o <= &(fc1_got | ifc1_mask);
                end
                DL_INIT2, DL_ACTIVE: begin
                    if (accept && (cls == CLS_UPDFC ||
                                   (state == DL_INIT2 && cls == CLS_INITFC2))) begin
                        state           <= DL_ACTIVE;
                        fc_init2_done_o <= 1'b1;
                    end
                    // Infinite-credit types keep their advertised limit forever.
                    if (accept && cls == CLS_UPDFC) begin
                        if (!inf_hdr_o[fc_idx])  hdr_cl[fc_idx]  <= hdr_fc;
                        if (!inf_data_o[fc_idx]) data_cl[fc_idx] <= data_fc;
                    end
                    if (state == DL_ACTIVE && accept && (cls == CLS_ACK || cls == CLS_NAK)) begin
                        ack_valid_o <= 1'b1;
                        ack_nak_o   <= (cls == CLS_NAK);
                        ack_seq_o   <= s1_dllp[11:0];
                    end
                end
                default: state <= DL_INACTIVE;
            endcase
        end
    end

    assign dl_state_o    = state;
    assign hdr_cl_p_o    = hdr_cl[0];
    assign hdr_cl_np_o   = hdr_cl[1];
    assign hdr_cl_cpl_o  = hdr_cl[2];
    assign data_cl_p_o   = data_cl[0];
    assign data_cl_np_o  = data_cl[1];
    assign data_cl_cpl_o = data_cl[2];

endmodule

// File: tb/tb_pcie_dllp_rx.sv
// Directed bench for pcie_dllp_rx: table of FC DLLPs with expected credit state,
// plus hand sequences for Ack/Nak timing, back-to-back updates, CRC and link-down.
module tb_pcie_dllp_rx;

    logic         sclk;
    logic         sreset_n;
    logic         link_up_i;
    logic         pipe_valid_i;
    logic [255:0] pipe_data_i;
    logic [1:0]   dl_state_o;
    logic         fc_init1_done_o, fc_init2_done_o;
    logic         ack_valid_o, ack_nak_o;
    logic [11:0]  ack_seq_o;
    logic [7:0]   hdr_cl_p_o, hdr_cl_np_o, hdr_cl_cpl_o;
    logic [11:0]  data_cl_p_o, data_cl_np_o, data_cl_cpl_o;
    logic [2:0]   inf_hdr_o, inf_data_o;
    logic         crc_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    pcie_dllp_rx #(.PIPE_DATA_WIDTH(256)) dut (
        .sclk            (sclk),
        .sreset_n        (sreset_n),
        .link_up_i       (link_up_i),
        .pipe_valid_i    (pipe_valid_i),
        .pipe_data_i     (pipe_data_i),
        .dl_state_o      (dl_state_o),
        .fc_init1_done_o (fc_init1_done_o),
        .fc_init2_done_o (fc_init2_done_o),
        .ack_valid_o     (ack_valid_o),
        .ack_nak_o       (ack_nak_o),
        .ack_seq_o       (ack_seq_o),
        .hdr_cl_p_o      (hdr_cl_p_o),
        .hdr_cl_np_o     (hdr_cl_np_o),
        .hdr_cl_cpl_o    (hdr_cl_cpl_o),
        .data_cl_p_o     (data_cl_p_o),
        .data_cl_np_o    (data_cl_np_o),
        .data_cl_cpl_o   (data_cl_cpl_o),
        .inf_hdr_o       (inf_hdr_o),
        .inf_data_o      (inf_data_o),
        .crc_err_o       (crc_err_o)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [7:0] b2, input logic [7:0] b3,
                                            input logic [7:0] b4, input logic [7:0] b5);
        logic [31:0] word;
        logic [15:0] r;
        logic        fb;
        word = {b2, b3, b4, b5};
        r    = 16'hFFFF;
        for (int k = 31; k >= 0; k--) begin
            fb = r[15] ^ word[k];
            r  = r << 1;
            if (fb) r = r ^ 16'h100B;
        end
        return r;
    endfunction

    function automatic logic [255:0] make_beat(input logic [7:0] t, input logic [7:0] b3,
                                               input logic [7:0] b4, input logic [7:0] b5,
                                               input logic bad_sdp, input logic bad_crc);
        logic [255:0] d;
        logic [15:0]  c;
        d         = {32{8'h5A}};
        d[7:0]    = 8'hF0;
        d[15:8]   = bad_sdp ? 8'hAD : 8'hAC;
        d[23:16]  = t;
        d[31:24]  = b3;
        d[39:32]  = b4;
        d[47:40]  = b5;
        c         = ref_crc(t, b3, b4, b5);
        d[55:48]  = c[15:8];
        d[63:56]  = c[7:0] ^ (bad_crc ? 8'hFF : 8'h00);
        return d;
    endfunction

    function automatic logic [255:0] fc_beat(input logic [7:0] t, input logic [7:0] hdr,
                                             input logic [11:0] dat, input logic bad_sdp,
                                             input logic bad_crc);
        return make_beat(t, {2'b00, hdr[7:2]}, {hdr[1:0], 2'b00, dat[11:8]}, dat[7:0],
                         bad_sdp, bad_crc);
    endfunction

    function automatic logic [255:0] ack_beat(input logic [7:0] t, input logic [11:0] seq);
        return make_beat(t, 8'h00, {4'h0, seq[11:8]}, seq[7:0], 1'b0, 1'b0);
    endfunction

    // Present one beat for a single cycle; returns 1 ns after the capturing edge.
    task automatic drive_beat(input logic [255:0] d, input logic v);
        pipe_data_i  = d;
        pipe_valid_i = v;
        @(posedge sclk); #1;
        pipe_valid_i = 1'b0;
        pipe_data_i  = '0;
    endtask

    typedef struct {
        logic [7:0]  typ;
        logic [7:0]  hdr;
        logic [11:0] dat;
        logic [1:0]  kind;   // 0 good, 1 corrupt SDP, 2 valid low
        logic [1:0]  st;
        logic [1:0]  done;   // {init2, init1}
        logic [23:0] hdrs;   // {cpl, np, p}
        logic [35:0] datas;  // {cpl, np, p}
        logic [5:0]  inf;    // {inf_hdr, inf_data}
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{8'h40, 8'h00, 12'h0FF, 2'd0, 2'd1, 2'b00, {8'h00, 8'h00, 8'h00}, {12'h000, 12'h000, 12'h0FF}, {3'b001, 3'b000}};
        vecs[1]  = '{8'h40, 8'h20, 12'h100, 2'd0, 2'd1, 2'b00, {8'h00, 8'h00, 8'h20}, {12'h000, 12'h000, 12'h100}, {3'b000, 3'b000}};
        vecs[2]  = '{8'h50, 8'h10, 12'h040, 2'd0, 2'd1, 2'b00, {8'h00, 8'h10, 8'h20}, {12'h000, 12'h040, 12'h100}, {3'b000, 3'b000}};
        vecs[3]  = '{8'h30, 8'h7F, 12'hFFF, 2'd0, 2'd1, 2'b00, {8'h00, 8'h10, 8'h20}, {12'h000, 12'h040, 12'h100}, {3'b000, 3'b000}};
        vecs[4]  = '{8'h60, 8'h00, 12'h000, 2'd0, 2'd1, 2'b01, {8'h00, 8'h10, 8'h20}, {12'h000, 12'h040, 12'h100}, {3'b100, 3'b100}};
        vecs[5]  = '{8'h40, 8'h77, 12'h777, 2'd0, 2'd2, 2'b01, {8'h00, 8'h10, 8'h20}, {12'h000, 12'h040, 12'h100}, {3'b100, 3'b100}};
        vecs[6]  = '{8'h90, 8'h11, 12'h041, 2'd0, 2'd3, 2'b11, {8'h00, 8'h11, 8'h20}, {12'h000, 12'h041, 12'h100}, {3'b100, 3'b100}};
        vecs[7]  = '{8'hA0, 8'h05, 12'h006, 2'd0, 2'd3, 2'b11, {8'h00, 8'h11, 8'h20}, {12'h000, 12'h041, 12'h100}, {3'b100, 3'b100}};
        vecs[8]  = '{8'h50, 8'h99, 12'h999, 2'd0, 2'd3, 2'b11, {8'h00, 8'h11, 8'h20}, {12'h000, 12'h041, 12'h100}, {3'b100, 3'b100}};
        vecs[9]  = '{8'h80, 8'h2A, 12'h200, 2'd0, 2'd3, 2'b11, {8'h00, 8'h11, 8'h2A}, {12'h000, 12'h041, 12'h200}, {3'b100, 3'b100}};
        vecs[10] = '{8'hE0, 8'h12, 12'h034, 2'd0, 2'd3, 2'b11, {8'h00, 8'h11, 8'h2A}, {12'h000, 12'h041, 12'h200}, {3'b100, 3'b100}};
        vecs[11] = '{8'h80, 8'h44, 12'h444, 2'd1, 2'd3, 2'b11, {8'h00, 8'h11, 8'h2A}, {12'h000, 12'h041, 12'h200}, {3'b100, 3'b100}};
        vecs[12] = '{8'h80, 8'h45, 12'h445, 2'd2, 2'd3, 2'b11, {8'h00, 8'h11, 8'h2A}, {12'h000, 12'h041, 12'h200}, {3'b100, 3'b100}};

        sreset_n     = 1'b0;
        link_up_i    = 1'b0;
        pipe_valid_i = 1'b0;
        pipe_data_i  = '0;
        repeat (2) @(posedge sclk);
        #1;
        check("reset outputs", 128'({dl_state_o, fc_init1_done_o, fc_init2_done_o, ack_valid_o,
              ack_nak_o, ack_seq_o, hdr_cl_p_o, hdr_cl_np_o, hdr_cl_cpl_o, data_cl_p_o,
              data_cl_np_o, data_cl_cpl_o, inf_hdr_o, inf_data_o, crc_err_o}), 128'(0));
        sreset_n = 1'b1;
        @(posedge sclk); #1;
        check("idle link down state", 128'(dl_state_o), 128'(0));
        link_up_i = 1'b1;
        @(posedge sclk); #1;
        check("link up -> INIT1", 128'(dl_state_o), 128'(1));

        drive_beat(ack_beat(8'h00, 12'h555), 1'b1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("ack in INIT1 dropped c%0d", c), 128'(ack_valid_o), 128'(0));
            @(posedge sclk); #1;
        end

        for (int i = 0; i < 13; i++) begin
            drive_beat(fc_beat(vecs[i].typ, vecs[i].hdr, vecs[i].dat, vecs[i].kind == 2'd1, 1'b0),
                       vecs[i].kind != 2'd2);
            @(posedge sclk); #1;
            check($sformatf("v%0d state", i), 128'(dl_state_o), 128'(vecs[i].st));
            check($sformatf("v%0d done", i), 128'({fc_init2_done_o, fc_init1_done_o}), 128'(vecs[i].done));
            check($sformatf("v%0d hdr", i), 128'({hdr_cl_cpl_o, hdr_cl_np_o, hdr_cl_p_o}), 128'(vecs[i].hdrs));
            check($sformatf("v%0d data", i), 128'({data_cl_cpl_o, data_cl_np_o, data_cl_p_o}), 128'(vecs[i].datas));
            check($sformatf("v%0d inf", i), 128'({inf_hdr_o, inf_data_o}), 128'(vecs[i].inf));
        end

        // Nak then Ack on consecutive beats: each appears exactly two edges later.
        drive_beat(ack_beat(8'h10, 12'h0AB), 1'b1);
        check("ack_valid before N+2", 128'(ack_valid_o), 128'(0));
        drive_beat(ack_beat(8'h00, 12'h123), 1'b1);
        check("nak pulse", 128'({ack_valid_o, ack_nak_o, ack_seq_o}), 128'({1'b1, 1'b1, 12'h0AB}));
        @(posedge sclk); #1;
        check("ack pulse", 128'({ack_valid_o, ack_nak_o, ack_seq_o}), 128'({1'b1, 1'b0, 12'h123}));
        @(posedge sclk); #1;
        check("ack pulse ends", 128'(ack_valid_o), 128'(0));

        drive_beat(fc_beat(8'h80, 8'h30, 12'h300, 1'b0, 1'b0), 1'b1);
        drive_beat(fc_beat(8'h80, 8'h31, 12'h301, 1'b0, 1'b0), 1'b1);
        check("b2b first hdr_p", 128'(hdr_cl_p_o), 128'(8'h30));
        @(posedge sclk); #1;
        check("b2b final hdr_p", 128'(hdr_cl_p_o), 128'(8'h31));
        check("b2b final data_p", 128'(data_cl_p_o), 128'(12'h301));

        drive_beat(fc_beat(8'h80, 8'h50, 12'h350, 1'b0, 1'b1), 1'b1);
        @(posedge sclk); #1;
`ifdef PCIE_DLLP_RX_CRC_CHECK_EN
        check("crc_err pulse", 128'(crc_err_o), 128'(1));
        check("bad crc hdr_p kept", 128'(hdr_cl_p_o), 128'(8'h31));
        @(posedge sclk); #1;
        check("crc_err pulse ends", 128'(crc_err_o), 128'(0));
`else
        check("crc_err tied low", 128'(crc_err_o), 128'(0));
        check("bad crc accepted hdr_p", 128'(hdr_cl_p_o), 128'(8'h50));
`endif

        drive_beat(fc_beat(8'h80, 8'h60, 12'h360, 1'b0, 1'b0), 1'b1);
        link_up_i = 1'b0;
        @(posedge sclk); #1;
        check("link down state", 128'(dl_state_o), 128'(0));
        check("link down flags", 128'({fc_init1_done_o, fc_init2_done_o, inf_hdr_o, inf_data_o,
              ack_valid_o, crc_err_o}), 128'(0));
        check("link down limits", 128'({hdr_cl_p_o, hdr_cl_np_o, hdr_cl_cpl_o, data_cl_p_o,
              data_cl_np_o, data_cl_cpl_o}), 128'(0));
        link_up_i = 1'b1;
        @(posedge sclk); #1;
        check("relink state", 128'(dl_state_o), 128'(1));
        @(posedge sclk); #1;
        check("flushed beat not applied", 128'({hdr_cl_p_o, data_cl_p_o}), 128'(0));

        #2;
        sreset_n = 1'b0;
        #1;
        check("async reset state", 128'(dl_state_o), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
